// File: rtl/multi_mode_timer.sv
// multi_mode_timer
//   Hour:minute:second stopwatch / countdown timer with an internal prescaler,
//   start/stop/clear/load control, lap capture, overflow and expiry flags.
//
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   mode                            0 = count up, 1 = count down (latched on start from IDLE)
//   start, stop, clear, load, lap   single-cycle command pulses
//   load_hour/minute/second         preload values (saturated to modulus-1)
//   cur_hour/minute/second          current count
//   lap_hour/minute/second          last captured count
//   lap_valid                       one-cycle pulse after a capture
//   running                         high while counting
//   overflow                        one-cycle pulse on up-count wrap to 0:0:0
//   expired                         level, countdown reached zero
//
// state | meaning
// IDLE  | cleared or preloaded, waiting for start
// RUN   | counting on every prescaler tick
// PAUSE | stopped, count and prescaler held
// DONE  | countdown reached zero, waits for clear or load
module multi_mode_timer #(
  parameter int HOUR     = 24,
  parameter int MINUTE   = 60,
  parameter int SECOND   = 60,
  parameter int TICK_DIV = 1,
  parameter int W        = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mode,
  input  logic         start,
  input  logic         stop,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_hour,
  input  logic [W-1:0] load_minute,
  input  logic [W-1:0] load_second,
  input  logic         lap,
  output logic [W-1:0] cur_hour,
  output logic [W-1:0] cur_minute,
  output logic [W-1:0] cur_second,
  output logic [W-1:0] lap_hour,
  output logic [W-1:0] lap_minute,
  output logic [W-1:0] lap_second,
  output logic         lap_valid,
  output logic         running,
  output logic         overflow,
  output logic         expired
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [W-1:0]  H_MAX = W'(HOUR - 1);
  localparam logic [W-1:0]  M_MAX = W'(MINUTE - 1);
  localparam logic [W-1:0]  S_MAX = W'(SECOND - 1);

  state_t        state;
  logic          mode_q;
  logic [PW-1:0] presc;
  logic          tick;
  logic          at_zero;
  logic          at_max;
  logic [W-1:0]  up_h, up_m, up_s;
  logic [W-1:0]  dn_h, dn_m, dn_s;

  function automatic logic [W-1:0] sat(input logic [W-1:0] v, input logic [W-1:0] mx);
    return (v > mx) ? mx : v;
  endfunction

  assign tick    = (state == RUN) && (presc == PRESC_LAST);
  assign at_zero = (cur_hour == '0) && (cur_minute == '0) && (cur_second == '0);
  assign at_max  = (cur_hour == H_MAX) && (cur_minute == M_MAX) && (cur_second == S_MAX);

  // Carry / borrow ripple for the next up and down values.
  always_comb begin
    up_s = (cur_second == S_MAX) ? '0 : cur_second + W'(1);
    up_m = cur_minute;
    up_h = cur_hour;
    if (cur_second == S_MAX) begin
      up_m = (cur_minute == M_MAX) ? '0 : cur_minute + W'(1);
      if (cur_minute == M_MAX)
        up_h = (cur_hour == H_MAX) ? '0 : cur_hour + W'(1);
    end
    dn_s = (cur_second == '0) ? S_MAX : cur_second - W'(1);
    dn_m = cur_minute;
    dn_h = cur_hour;
    if (cur_second == '0) begin
      dn_m = (cur_minute == '0) ? M_MAX : cur_minute - W'(1);
      if (cur_minute == '0)
        dn_h = (cur_hour == '0) ? H_MAX : cur_hour - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mode_q     <= 1'b0;
      presc      <= '0;
      cur_hour   <= '0;
      cur_minute <= '0;
      cur_second <= '0;
      lap_hour   <= '0;
      lap_minute <= '0;
      lap_second <= '0;
      lap_valid  <= 1'b0;
      running    <= 1'b0;
      overflow   <= 1'b0;
      expired    <= 1'b0;
    end else begin
      lap_valid <= 1'b0;
      overflow  <= 1'b0;

      // Lap samples the pre-tick count and is independent of the commands.
      if (lap && state != IDLE) begin
        lap_hour   <= cur_hour;
        lap_minute <= cur_minute;
        lap_second <= cur_second;
        lap_valid  <= 1'b1;
      end

      if (clear) begin
        state      <= IDLE;
        running    <= 1'b0;
        presc      <= '0;
        cur_hour   <= '0;
        cur_minute <= '0;
        cur_second <= '0;
        expired    <= 1'b0;
      end else if (load && state != RUN) begin
        cur_hour   <= sat(load_hour, H_MAX);
        cur_minute <= sat(load_minute, M_MAX);
        cur_second <= sat(load_second, S_MAX);
        presc      <= '0;
        expired    <= 1'b0;
        if (state == DONE)
          state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start && !stop) begin
              mode_q <= mode;
              presc  <= '0;
              if (mode && at_zero) begin
                state   <= DONE;
                expired <= 1'b1;
              end else begin
                state   <= RUN;
                running <= 1'b1;
              end
            end
          end
          RUN: begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick && mode_q && at_zero) begin
              // Zero is never decremented; reaching it ends the countdown.
              state   <= DONE;
              running <= 1'b0;
              expired <= 1'b1;
            end else begin
              if (tick) begin
                if (!mode_q) begin
                  cur_hour   <= up_h;
                  cur_minute <= up_m;
                  cur_second <= up_s;
                  overflow   <= at_max;
                end else begin
                  cur_hour   <= dn_h;
                  cur_minute <= dn_m;
                  cur_second <= dn_s;
                end
              end
              if (stop) begin
                state   <= PAUSE;
                running <= 1'b0;
              end
            end
          end
          PAUSE: begin
            if (start && !stop) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
